fp_align_add: RTL
=================

// Module: fp_align_add
// PURPOSE
//  Sequential exponent-compare / significand-align / add stage of the small FP adder
//  (EW-bit exponent, MW-bit mantissa, hidden 1, no sign: magnitude add only).
//  Accepts one operand pair per transaction and aligns the smaller operand by one bit per cycle.
//  Produces XeLTYe, Xe, Ye and the (MW+2)-bit raw sum that the downstream normalise/exponent-gen stage consumes.
//  Output is held until that stage accepts it (valid/ready).
// PARAMETERS
//  EW  4  exponent width
//  MW  7  stored mantissa width; significand = {1'b1, m} is MW+1 bits; sum is MW+2 bits
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       asynchronous reset, active low
//  in_valid  in   1       operand pair valid
//  in_ready  out  1       block can accept (state IDLE)
//  Xe, Ye    in   EW      operand exponents
//  Xm, Ym    in   MW      operand stored mantissas
//  out_valid out  1       result valid (state DONE)
//  out_ready in   1       downstream accepts result
//  XeLTYe    out  1       registered (Xe < Ye), unsigned
//  Xe_o,Ye_o out  EW      registered copies of accepted Xe, Ye
//  sum       out  MW+2    {carry, aligned significand sum}
//  sticky    out  1       OR of all bits shifted out of smaller significand (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; out_valid=0, XeLTYe=0, Xe_o=Ye_o=0, sum=0, sticky=0;
//    in_ready=1 (decoded from IDLE). Reset mid-operation aborts silently; no partial result is emitted.
//  - FSM: IDLE, ALIGN, ADD, DONE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  - IDLE: on in_valid & in_ready: latch Xe_o/Ye_o; XeLTYe = Xe<Ye.
//    Large significand L = {1,XeLTYe?Ym:Xm}; small S = {1,XeLTYe?Xm:Ym}; tie (Xe==Ye) selects X as large.
//    d = |Xe-Ye|; cnt = min(d, MW+1); sticky register cleared.
//    Next state: ALIGN if cnt!=0, else ADD.
//  - ALIGN: each cycle S <= S>>1; stk <= stk | S[0]; cnt <= cnt-1; go to ADD when cnt==1.
//    Exactly cnt cycles are spent here; a shift >= MW+1 leaves S=0.
//  - ADD: sum <= L + S (zero-extended to MW+2, no overflow possible); state DONE.
//  - DONE: outputs stable while out_ready=0; on out_ready=1 -> IDLE.
//    in_valid in any non-IDLE state is ignored (not captured).
//  - Latency: accept edge k -> out_valid high after edge k+cnt+1.
//    Throughput: one result per cnt+3 cycles (IDLE occupies >= 1 cycle between results).
//  - All outputs are registers or a pure decode of state; no input->output combinational path.
//  - Downstream selects the greater exponent as Ge = XeLTYe ? Ye_o : Xe_o.
// CONFIGURATION
//  FP_ALIGN_STICKY_EN defined: sticky output = OR of all bits shifted out of S during ALIGN, valid with out_valid.
//    When the shift is capped (d > MW+1), every bit of S is shifted out, so sticky=1.
//  Not defined: sticky tied to 0; no sticky register is synthesised. Port list unchanged.
// TESTING
//  1. Xe=5,Xm=0x00,Ye=5,Ym=0x00 -> XeLTYe=0, sum=0x100, sticky=0, out_valid after edge k+1
//  2. Xe=3,Xm=0x40,Ye=5,Ym=0x00 -> XeLTYe=1, S=0xC0>>2=0x30, sum=0x0B0, sticky=0, out_valid after edge k+3
//  3. Xe=12,Xm=0x15,Ye=1,Ym=0x7F -> cnt capped 8, sum=0x095, sticky=1 (STICKY_EN) / 0 (not), out_valid after edge k+9
//  4. Case 2 with out_ready=0 for 5 cycles + in_valid pulses -> outputs constant, in_ready=0, nothing captured; out_ready=1 -> IDLE next edge
//  5. Xe=9,Ye=3 accepted, rst_n low 2 cycles into ALIGN -> out_valid=0 and in_ready=1 immediately; after release, case 1 gives sum=0x100
//  6. 20 random pairs, out_ready=1, in_valid=1 -> each sum matches reference model; sticky matches when STICKY_EN; spacing cnt+3 cycles

Source files
------------

// File: rtl/fp_align_add_if.sv
// Operand/result handshake bundle for the FP exponent-compare / align / add stage.
// Port names follow the downstream normalise stage's existing naming.
interface fp_align_add_if #(
  parameter int unsigned EW = 4,
  parameter int unsigned MW = 7
);
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] Xe;
  logic [EW-1:0] Ye;
  logic [MW-1:0] Xm;
  logic [MW-1:0] Ym;
  logic          out_valid;
  logic          out_ready;
  logic          XeLTYe;
  logic [EW-1:0] Xe_o;
  logic [EW-1:0] Ye_o;
  logic [MW+1:0] sum;
  logic          sticky;

  modport master (
    output in_valid, Xe, Ye, Xm, Ym, out_ready,
    input  in_ready, out_valid, XeLTYe, Xe_o, Ye_o, sum, sticky
  );

  modport slave (
    input  in_valid, Xe, Ye, Xm, Ym, out_ready,
    output in_ready, out_valid, XeLTYe, Xe_o, Ye_o, sum, sticky
  );
endinterface

// File: rtl/fp_align_add.sv
// Sequential exponent-compare / significand-align (1 bit per cycle) / magnitude-add stage.
// Optional FP_ALIGN_STICKY_EN: build the sticky register; otherwise sticky is tied low.
module fp_align_add #(
  parameter int unsigned EW = 4,
  parameter int unsigned MW = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_align_add_if.slave  bus
);
  localparam int unsigned SW   = MW + 1;
  localparam int unsigned SUMW = MW + 2;
  localparam int unsigned CW   = $clog2(MW + 2);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [SW-1:0]   l_q,     l_d;
  logic [SW-1:0]   s_q,     s_d;
  logic [EW-1:0]   xe_q,    xe_d;
  logic [EW-1:0]   ye_q,    ye_d;
  logic            lt_q,    lt_d;
  logic [SUMW-1:0] sum_q,   sum_d;
`ifdef FP_ALIGN_STICKY_EN
  logic            stk_q,   stk_d;
`endif

  logic            lt_c;
  logic [EW-1:0]   diff_c;
  logic [CW-1:0]   shamt_c;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    s_d     = s_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    lt_d    = lt_q;
    sum_d   = sum_q;
`ifdef FP_ALIGN_STICKY_EN
    stk_d   = stk_q;
`endif

    lt_c   = bus.Xe < bus.Ye;
    diff_c = lt_c ? (bus.Ye - bus.Xe) : (bus.Xe - bus.Ye);
    // Shifting by more than the significand width just empties it, so cap the count
    if (32'(diff_c) > SW) shamt_c = CW'(SW);
    else                  shamt_c = CW'(diff_c);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          xe_d  = bus.Xe;
          ye_d  = bus.Ye;
          lt_d  = lt_c;
          l_d   = {1'b1, (lt_c ? bus.Ym : bus.Xm)};
          s_d   = {1'b1, (lt_c ? bus.Xm : bus.Ym)};
          cnt_d = shamt_c;
`ifdef FP_ALIGN_STICKY_EN
          stk_d = 1'b0;
`endif
          state_d = (shamt_c != '0) ? ALIGN : ADD;
        end
      end
      ALIGN: begin
        s_d   = s_q >> 1;
        cnt_d = cnt_q - CW'(1);
`ifdef FP_ALIGN_STICKY_EN
        stk_d = stk_q | s_q[0];
`endif
        if (cnt_q == CW'(1)) state_d = ADD;
      end
      ADD: begin
        sum_d   = SUMW'(l_q) + SUMW'(s_q);
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      s_q     <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      lt_q    <= 1'b0;
      sum_q   <= '0;
`ifdef FP_ALIGN_STICKY_EN
      stk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      s_q     <= s_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      lt_q    <= lt_d;
      sum_q   <= sum_d;
`ifdef FP_ALIGN_STICKY_EN
      stk_q   <= stk_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.XeLTYe    = lt_q;
  assign bus.Xe_o      = xe_q;
  assign bus.Ye_o      = ye_q;
  assign bus.sum       = sum_q;
`ifdef FP_ALIGN_STICKY_EN
  assign bus.sticky    = stk_q;
`else
  assign bus.sticky    = 1'b0;
`endif
endmodule
